// File: rtl/ctrl_pkg.sv
// Shared types and constants for the instruction controller: FSM state
// encoding, the registered control-output bundle, ARM condition codes and
// the compare-class ALU opcode range.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    COND,
    OPER,
    EXEC,
    WB,
    TRAP
  } state_e;

  // ARM condition field encodings (instruction bits [INSTR_W-1:INSTR_W-4]).
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // TST/TEQ/CMP/CMN only update flags and never write the register file.
  localparam logic [3:0] ALU_CMP_LO = 4'd8;
  localparam logic [3:0] ALU_CMP_HI = 4'd11;

  // Every datapath strobe and control the FSM drives, registered as one unit.
  typedef struct packed {
    logic       write_pc;
    logic       write_ir;
    logic       write_reg;
    logic       la;
    logic       lb;
    logic       lc;
    logic       lf;
    logic       s_ctrl;
    logic       rm_imm_s_ctrl;
    logic [1:0] rs_imm_s_ctrl;
    logic [2:0] shift_op_ctrl;
    logic [3:0] alu_op_ctrl;
    logic       und_trap;
  } ctrl_t;

  // Returns 1 when condition field cc passes against flags {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = nzcv;
    case (cc)
      CC_EQ:   pass = z;
      CC_NE:   pass = !z;
      CC_CS:   pass = c;
      CC_CC:   pass = !c;
      CC_MI:   pass = n;
      CC_PL:   pass = !n;
      CC_VS:   pass = v;
      CC_VC:   pass = !v;
      CC_HI:   pass = c && !z;
      CC_LS:   pass = !c || z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = !z && (n == v);
      CC_LE:   pass = z || (n != v);
      CC_AL:   pass = 1'b1;
      CC_NV:   pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Compare-class opcodes suppress the register write-back.
  function automatic logic is_compare(input logic [3:0] alu_op);
    return (alu_op >= ALU_CMP_LO) && (alu_op <= ALU_CMP_HI);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction prefetch queue: DEPTH entries of INSTR_W bits, power-of-two
// depth so pointers wrap naturally. No bypass: data pushed this cycle is
// visible at the head no earlier than the next cycle. clr_i empties the
// queue and drops any push in the same cycle. Reset is synchronous, active-low.
module instr_fifo #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int OCC_W  = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [INSTR_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [OCC_W-1:0]   occupancy_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [OCC_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o      = (count_q == OCC_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign occupancy_o = count_q;
  assign head_o      = mem_q[rd_ptr_q];

  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  // Storage array: written on accepted pushes only.
  // NOTE: the data array is deliberately not reset; the pointers and count
  // alone define which entries are valid, so clearing it would only add logic.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and fill-level bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_queue_fsm.sv
// Multi-cycle instruction controller. Instructions arrive through a
// ready/valid push into instr_fifo, are issued one at a time onto cur_ir,
// condition-checked against flags_nzcv, then sequenced through
// OPER/EXEC/WB (or TRAP for undefined instructions). All strobes are
// registered alongside the state, so each strobe is high during the cycle
// its state is current. Reset is synchronous, active-low.
// Optional feature: define CTRL_PERF_CNT_EN to build the retired/skipped
// performance counters; otherwise both counter ports are tied to zero.
module ctrl_queue_fsm
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic [3:0]             flags_nzcv,
  input  logic                   rm_imm_s,
  input  logic [1:0]             rs_imm_s,
  input  logic [2:0]             shift_op,
  input  logic [3:0]             alu_op,
  input  logic                   s_bit,
  input  logic                   und_ins,
  output logic [INSTR_W-1:0]     cur_ir,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   write_pc,
  output logic                   write_ir,
  output logic                   write_reg,
  output logic                   LA,
  output logic                   LB,
  output logic                   LC,
  output logic                   LF,
  output logic                   S_ctrl,
  output logic                   rm_imm_s_ctrl,
  output logic [1:0]             rs_imm_s_ctrl,
  output logic [2:0]             Shift_OP_ctrl,
  output logic [3:0]             ALU_OP_ctrl,
  output logic                   und_trap,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic [CNT_W-1:0]       skipped_cnt
);

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [INSTR_W-1:0] cur_ir_q, cur_ir_d;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic               cc_pass;

  // Prefetch queue; flush clears it and drops any same-cycle push.
  instr_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush),
    .push_i      (in_valid),
    .push_data_i (in_instr),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (occupancy)
  );

  assign in_ready = !fifo_full;

  // cur_ir is stable from COND onward, so its condition field is valid here.
  assign cc_pass = cond_pass(cur_ir_q[INSTR_W-1 -: 4], flags_nzcv);

  // Next-state and next-strobe decode. Strobes are computed for the state
  // being entered, so they appear in the same cycle as that state.
  // NOTE: every variable gets a default at the top of this block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = '0;
    cur_ir_d = cur_ir_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d         = ISSUE;
          ctrl_d.write_ir = 1'b1;
        end
      end

      ISSUE: begin
        fifo_pop = 1'b1;
        cur_ir_d = fifo_head;
        state_d  = COND;
      end

      COND: begin
        if (!cc_pass) begin
          state_d = IDLE;
        end else if (und_ins) begin
          state_d         = TRAP;
          ctrl_d.und_trap = 1'b1;
          ctrl_d.write_pc = 1'b1;
        end else begin
          state_d              = OPER;
          ctrl_d.la            = 1'b1;
          ctrl_d.lb            = 1'b1;
          ctrl_d.rm_imm_s_ctrl = rm_imm_s;
          ctrl_d.rs_imm_s_ctrl = rs_imm_s;
        end
      end

      OPER: begin
        state_d              = EXEC;
        ctrl_d.lc            = 1'b1;
        ctrl_d.shift_op_ctrl = shift_op;
        ctrl_d.alu_op_ctrl   = alu_op;
        ctrl_d.lf            = s_bit;
        ctrl_d.s_ctrl        = s_bit;
      end

      EXEC: begin
        state_d          = WB;
        ctrl_d.write_pc  = 1'b1;
        ctrl_d.write_reg = !is_compare(alu_op);
      end

      WB: begin
        if (!fifo_empty) begin
          state_d         = ISSUE;
          ctrl_d.write_ir = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      TRAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush discards the in-flight instruction; strobes registered for the
    // current cycle have already been emitted and simply drop next cycle.
    if (flush) begin
      state_d  = IDLE;
      ctrl_d   = '0;
      cur_ir_d = '0;
      fifo_pop = 1'b0;
    end
  end

  // State, in-flight instruction and strobes advance together; reset wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      cur_ir_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      cur_ir_q <= cur_ir_d;
    end
  end

  assign cur_ir        = cur_ir_q;
  assign write_pc      = ctrl_q.write_pc;
  assign write_ir      = ctrl_q.write_ir;
  assign write_reg     = ctrl_q.write_reg;
  assign LA            = ctrl_q.la;
  assign LB            = ctrl_q.lb;
  assign LC            = ctrl_q.lc;
  assign LF            = ctrl_q.lf;
  assign S_ctrl        = ctrl_q.s_ctrl;
  assign rm_imm_s_ctrl = ctrl_q.rm_imm_s_ctrl;
  assign rs_imm_s_ctrl = ctrl_q.rs_imm_s_ctrl;
  assign Shift_OP_ctrl = ctrl_q.shift_op_ctrl;
  assign ALU_OP_ctrl   = ctrl_q.alu_op_ctrl;
  assign und_trap      = ctrl_q.und_trap;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] skipped_q;
  logic             retire_evt;
  logic             skip_evt;

  // A flushed instruction is neither retired nor skipped.
  assign retire_evt = (state_q == WB) && !flush;
  assign skip_evt   = (state_q == COND) && !cc_pass && !flush;

  // Free-running event counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_q <= '0;
      skipped_q <= '0;
    end else begin
      if (retire_evt) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (skip_evt) begin
        skipped_q <= skipped_q + CNT_W'(1);
      end
    end
  end

  assign retired_cnt = retired_q;
  assign skipped_cnt = skipped_q;
`else
  assign retired_cnt = '0;
  assign skipped_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_queue_fsm.sv
// Self-checking bench for ctrl_queue_fsm: a table of single-instruction
// vectors covering every pass/skip/trap outcome and condition-code classes,
// plus hand-written sequences for queue-full, flush and mid-instruction reset.
module tb_ctrl_queue_fsm;

  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [INSTR_W-1:0] in_instr;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [3:0]         flags_nzcv;
  logic               rm_imm_s;
  logic [1:0]         rs_imm_s;
  logic [2:0]         shift_op;
  logic [3:0]         alu_op;
  logic               s_bit;
  logic               und_ins;
  logic [INSTR_W-1:0] cur_ir;
  logic [$clog2(DEPTH):0] occupancy;
  logic               write_pc, write_ir, write_reg;
  logic               LA, LB, LC, LF, S_ctrl, rm_imm_s_ctrl;
  logic [1:0]         rs_imm_s_ctrl;
  logic [2:0]         Shift_OP_ctrl;
  logic [3:0]         ALU_OP_ctrl;
  logic               und_trap;
  logic [CNT_W-1:0]   retired_cnt, skipped_cnt;

  ctrl_queue_fsm #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_instr      (in_instr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush         (flush),
    .flags_nzcv    (flags_nzcv),
    .rm_imm_s      (rm_imm_s),
    .rs_imm_s      (rs_imm_s),
    .shift_op      (shift_op),
    .alu_op        (alu_op),
    .s_bit         (s_bit),
    .und_ins       (und_ins),
    .cur_ir        (cur_ir),
    .occupancy     (occupancy),
    .write_pc      (write_pc),
    .write_ir      (write_ir),
    .write_reg     (write_reg),
    .LA            (LA),
    .LB            (LB),
    .LC            (LC),
    .LF            (LF),
    .S_ctrl        (S_ctrl),
    .rm_imm_s_ctrl (rm_imm_s_ctrl),
    .rs_imm_s_ctrl (rs_imm_s_ctrl),
    .Shift_OP_ctrl (Shift_OP_ctrl),
    .ALU_OP_ctrl   (ALU_OP_ctrl),
    .und_trap      (und_trap),
    .retired_cnt   (retired_cnt),
    .skipped_cnt   (skipped_cnt)
  );

  always #5 clk = ~clk;

  // Snapshot of all strobes/controls, compared as one word per cycle.
  typedef struct packed {
    logic       write_ir;
    logic       la;
    logic       lb;
    logic       lc;
    logic       lf;
    logic       s_ctrl;
    logic       write_pc;
    logic       write_reg;
    logic       und_trap;
    logic       rm;
    logic [1:0] rs;
    logic [2:0] sh;
    logic [3:0] alu;
  } ctl_t;

  typedef enum logic [1:0] {K_PASS, K_SKIP, K_TRAP} kind_e;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  nzcv;
    logic        und;
    logic [3:0]  alu;
    logic        s;
    logic        rm;
    logic [1:0]  rs;
    logic [2:0]  sh;
    kind_e       kind;
    logic        wreg;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;
  int exp_skip = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t obs();
    ctl_t o;
    o.write_ir  = write_ir;
    o.la        = LA;
    o.lb        = LB;
    o.lc        = LC;
    o.lf        = LF;
    o.s_ctrl    = S_ctrl;
    o.write_pc  = write_pc;
    o.write_reg = write_reg;
    o.und_trap  = und_trap;
    o.rm        = rm_imm_s_ctrl;
    o.rs        = rs_imm_s_ctrl;
    o.sh        = Shift_OP_ctrl;
    o.alu       = ALU_OP_ctrl;
    return o;
  endfunction

  task automatic check_cnt(input string tag);
`ifdef CTRL_PERF_CNT_EN
    check({tag, "_retired"}, 64'(retired_cnt), 64'(exp_ret));
    check({tag, "_skipped"}, 64'(skipped_cnt), 64'(exp_skip));
`else
    check({tag, "_retired"}, 64'(retired_cnt), 64'd0);
    check({tag, "_skipped"}, 64'(skipped_cnt), 64'd0);
`endif
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] nzcv,
                              input logic und, input logic [3:0] alu, input logic s,
                              input logic rm, input logic [1:0] rs, input logic [2:0] sh,
                              input kind_e kind, input logic wreg);
    vec_t v;
    v.instr = instr; v.nzcv = nzcv; v.und = und; v.alu = alu; v.s = s;
    v.rm = rm; v.rs = rs; v.sh = sh; v.kind = kind; v.wreg = wreg;
    return v;
  endfunction

  // Drive the decoder-side fields for a plain AL ADD.
  task automatic set_add_fields();
    flags_nzcv = 4'b0000; und_ins = 1'b0; alu_op = 4'd4; s_bit = 1'b0;
    rm_imm_s = 1'b0; rs_imm_s = 2'b00; shift_op = 3'b000;
  endtask

  ctl_t exp_c;
  ctl_t zero_c;
  logic [31:0] seen[$];
  int extra;

  initial begin
    zero_c = '0;
    rst = 1'b0; in_instr = '0; in_valid = 1'b0; flush = 1'b0;
    set_add_fields();

    //                instr          NZCV     und  alu   s     rm    rs     sh      kind    wreg
    vecs[0]  = mk(32'hE0810002, 4'b0000, 1'b0, 4'd4,  1'b0, 1'b1, 2'b10, 3'b011, K_PASS, 1'b1); // AL ADD
    vecs[1]  = mk(32'h00810002, 4'b0000, 1'b0, 4'd4,  1'b0, 1'b0, 2'b00, 3'b000, K_SKIP, 1'b0); // EQ, Z=0
    vecs[2]  = mk(32'h00810002, 4'b0100, 1'b0, 4'd4,  1'b0, 1'b0, 2'b01, 3'b101, K_PASS, 1'b1); // EQ, Z=1
    vecs[3]  = mk(32'h10810002, 4'b0100, 1'b0, 4'd4,  1'b0, 1'b0, 2'b00, 3'b000, K_SKIP, 1'b0); // NE, Z=1
    vecs[4]  = mk(32'h80810002, 4'b0010, 1'b0, 4'd2,  1'b1, 1'b1, 2'b11, 3'b001, K_PASS, 1'b1); // HI, C&!Z
    vecs[5]  = mk(32'h90810002, 4'b0010, 1'b0, 4'd2,  1'b0, 1'b0, 2'b00, 3'b000, K_SKIP, 1'b0); // LS, C&!Z
    vecs[6]  = mk(32'hA0810002, 4'b1001, 1'b0, 4'd12, 1'b0, 1'b0, 2'b00, 3'b010, K_PASS, 1'b1); // GE, N=V, ORR
    vecs[7]  = mk(32'hB0810002, 4'b1000, 1'b0, 4'd8,  1'b1, 1'b0, 2'b00, 3'b000, K_PASS, 1'b0); // LT, TST
    vecs[8]  = mk(32'hC0810002, 4'b0100, 1'b0, 4'd4,  1'b0, 1'b0, 2'b00, 3'b000, K_SKIP, 1'b0); // GT, Z=1
    vecs[9]  = mk(32'hD0810002, 4'b0001, 1'b0, 4'd11, 1'b1, 1'b1, 2'b00, 3'b000, K_PASS, 1'b0); // LE, N!=V, CMN
    vecs[10] = mk(32'hF0810002, 4'b1111, 1'b0, 4'd4,  1'b0, 1'b0, 2'b00, 3'b000, K_SKIP, 1'b0); // NV
    vecs[11] = mk(32'hE0810002, 4'b0000, 1'b0, 4'd10, 1'b1, 1'b0, 2'b00, 3'b000, K_PASS, 1'b0); // AL CMP
    vecs[12] = mk(32'hE0810002, 4'b0000, 1'b1, 4'd4,  1'b0, 1'b0, 2'b00, 3'b000, K_TRAP, 1'b0); // AL undef
    vecs[13] = mk(32'h00810002, 4'b0000, 1'b1, 4'd4,  1'b0, 1'b0, 2'b00, 3'b000, K_SKIP, 1'b0); // EQ fail, undef
    vecs[14] = mk(32'h60810002, 4'b0001, 1'b0, 4'd7,  1'b0, 1'b0, 2'b10, 3'b100, K_PASS, 1'b1); // VS, V=1

    // ---- reset state ----
    step(); step();
    check("rst_ctl", 64'(obs()), 64'(zero_c));
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_cur_ir", 64'(cur_ir), 64'd0);
    check_cnt("rst");
    rst = 1'b1;
    step();

    // ---- table-driven single instructions ----
    for (int i = 0; i < NVEC; i++) begin
      flags_nzcv = vecs[i].nzcv; und_ins = vecs[i].und; alu_op = vecs[i].alu;
      s_bit = vecs[i].s; rm_imm_s = vecs[i].rm; rs_imm_s = vecs[i].rs; shift_op = vecs[i].sh;
      in_instr = vecs[i].instr; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_occ_push", i), 64'(occupancy), 64'd1);
      step(); // ISSUE
      exp_c = '0; exp_c.write_ir = 1'b1;
      check($sformatf("v%0d_issue", i), 64'(obs()), 64'(exp_c));
      step(); // COND
      check($sformatf("v%0d_cond", i), 64'(obs()), 64'(zero_c));
      check($sformatf("v%0d_cur_ir", i), 64'(cur_ir), 64'(vecs[i].instr));
      step();
      case (vecs[i].kind)
        K_SKIP: begin
          exp_skip++;
          check($sformatf("v%0d_skip", i), 64'(obs()), 64'(zero_c));
          check_cnt($sformatf("v%0d", i));
        end
        K_TRAP: begin
          exp_c = '0; exp_c.und_trap = 1'b1; exp_c.write_pc = 1'b1;
          check($sformatf("v%0d_trap", i), 64'(obs()), 64'(exp_c));
          step();
          check($sformatf("v%0d_post_trap", i), 64'(obs()), 64'(zero_c));
          check_cnt($sformatf("v%0d", i));
        end
        default: begin
          exp_c = '0; exp_c.la = 1'b1; exp_c.lb = 1'b1;
          exp_c.rm = vecs[i].rm; exp_c.rs = vecs[i].rs;
          check($sformatf("v%0d_oper", i), 64'(obs()), 64'(exp_c));
          step();
          exp_c = '0; exp_c.lc = 1'b1; exp_c.lf = vecs[i].s; exp_c.s_ctrl = vecs[i].s;
          exp_c.sh = vecs[i].sh; exp_c.alu = vecs[i].alu;
          check($sformatf("v%0d_exec", i), 64'(obs()), 64'(exp_c));
          step();
          exp_c = '0; exp_c.write_pc = 1'b1; exp_c.write_reg = vecs[i].wreg;
          check($sformatf("v%0d_wb", i), 64'(obs()), 64'(exp_c));
          step();
          exp_ret++;
          check($sformatf("v%0d_post_wb", i), 64'(obs()), 64'(zero_c));
          check_cnt($sformatf("v%0d", i));
        end
      endcase
    end

    // ---- queue fills while the first instruction executes ----
    set_add_fields();
    in_instr = 32'hE1000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); // ISSUE A
    step(); // COND A
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_instr = 32'hE2000000 + 32'(k);
      step();
    end
    // Now in ISSUE of the second instruction with four entries queued.
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_write_ir", 64'(write_ir), 64'd1);
    in_instr = 32'hEDEADBEE; // dropped: queue full
    step();
    in_valid = 1'b0;
    check("pop_occ", 64'(occupancy), 64'd3);
    check("pop_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 60 && seen.size() < 4; c++) begin
      step();
      if (LA) seen.push_back(cur_ir);
    end
    check("drain_count", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      check($sformatf("drain_order%0d", k), 64'(seen[k]), 64'(32'hE2000000 + 32'(k)));
    end
    step(); step(); step(); // EXEC, WB, IDLE
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (write_ir) extra++;
      step();
    end
    check("dropped_push_not_issued", 64'(extra), 64'd0);
    check("drain_occ", 64'(occupancy), 64'd0);
    exp_ret += 5;
    check_cnt("drain");

    // ---- flush during EXEC with two queued ----
    in_instr = 32'hE3000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); // ISSUE
    step(); // COND
    in_valid = 1'b1; in_instr = 32'hE3000002;
    step(); // OPER
    in_instr = 32'hE3000003;
    step(); // EXEC
    check("flush_pre_lc", 64'(LC), 64'd1);
    check("flush_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1; in_instr = 32'hE3000004; // push dropped by flush
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_ctl", 64'(obs()), 64'(zero_c));
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_cur_ir", 64'(cur_ir), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (write_ir || write_pc) extra++;
    end
    check("flush_quiet", 64'(extra), 64'd0);
    check_cnt("flush");

    // ---- reset mid-OPER overrides flush and push ----
    in_instr = 32'hE4000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); // ISSUE
    step(); // COND
    in_valid = 1'b1; in_instr = 32'hE4000002;
    step(); // OPER
    check("rst_mid_pre_la", 64'(LA), 64'd1);
    rst = 1'b0; flush = 1'b1; in_instr = 32'hE4000003;
    step();
    exp_ret = 0; exp_skip = 0;
    check("rst_mid_ctl", 64'(obs()), 64'(zero_c));
    check("rst_mid_occ", 64'(occupancy), 64'd0);
    check("rst_mid_cur_ir", 64'(cur_ir), 64'd0);
    check_cnt("rst_mid");
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step(); step();
    check("rst_mid_idle", 64'(write_ir), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
